// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: requester encodings and default
// datapath geometry (common with the ALU).
package shift_arbiter_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int DEF_N = 32;
    localparam int DEF_M = 5;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Combinational barrel shifter: logical left with zero fill, or arithmetic
// right replicating the sign bit.
module barrel_shifter
    import shift_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    output logic [N-1:0] out,
    input  logic [N-1:0] in,
    input  logic [M-1:0] shiftamt,
    input  logic         left
);

    always_comb begin
        if (left) begin
            out = in << shiftamt;
        end else begin
            out = N'($signed(in) >>> shiftamt);
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one barrel shifter between requesters A and B, with a
// one-entry registered result buffer tagged by source.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [N-1:0] a_data,
    input  logic [M-1:0] a_shamt,
    input  logic         a_left,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [N-1:0] b_data,
    input  logic [M-1:0] b_shamt,
    input  logic         b_left,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_src
);

    logic         res_valid_q, res_valid_d;
    logic [N-1:0] res_data_q,  res_data_d;
    logic         res_src_q,   res_src_d;
    logic         last_grant_q, last_grant_d;

    logic         can_accept;
    logic         grant_src;
    logic         accept;
    logic [N-1:0] sh_in;
    logic [M-1:0] sh_amt;
    logic         sh_left;
    logic [N-1:0] sh_out;

    // Reset also masks the readies so nothing is accepted while held in reset.
    always_comb begin
        can_accept = reset_n && (!res_valid_q || res_ready);

        if (a_valid && b_valid) begin
            grant_src = ~last_grant_q;
        end else if (b_valid) begin
            grant_src = SRC_B;
        end else begin
            grant_src = SRC_A;
        end

        a_ready = can_accept && a_valid && (grant_src == SRC_A);
        b_ready = can_accept && b_valid && (grant_src == SRC_B);
        accept  = a_ready || b_ready;

        if (grant_src == SRC_B) begin
            sh_in   = b_data;
            sh_amt  = b_shamt;
            sh_left = b_left;
        end else begin
            sh_in   = a_data;
            sh_amt  = a_shamt;
            sh_left = a_left;
        end
    end

    barrel_shifter #(
        .N (N),
        .M (M)
    ) u_shifter (
        .out      (sh_out),
        .in       (sh_in),
        .shiftamt (sh_amt),
        .left     (sh_left)
    );

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_src_d    = res_src_q;
        last_grant_d = last_grant_q;

        if (accept) begin
            res_valid_d  = 1'b1;
            res_data_d   = sh_out;
            res_src_d    = grant_src;
            last_grant_d = grant_src;
        end else if (res_ready) begin
            res_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_src_q    <= SRC_A;
            last_grant_q <= SRC_B;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_src_q    <= res_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_src   = res_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter with hand-computed expectations.
module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a_valid, a_ready, a_left;
    logic [31:0] a_data;
    logic [4:0]  a_shamt;
    logic        b_valid, b_ready, b_left;
    logic [31:0] b_data;
    logic [4:0]  b_shamt;
    logic        res_valid, res_ready, res_src;
    logic [31:0] res_data;

    int unsigned total;
    int unsigned bad;

    shift_arbiter #(
        .N (32),
        .M (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_shamt   (a_shamt),
        .a_left    (a_left),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_shamt   (b_shamt),
        .b_left    (b_left),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_src   (res_src)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] s, input logic l);
        a_valid = v; a_data = d; a_shamt = s; a_left = l;
    endtask

    task automatic set_b(input logic v, input logic [31:0] d, input logic [4:0] s, input logic l);
        b_valid = v; b_data = d; b_shamt = s; b_left = l;
    endtask

    task automatic check_res(input string tag, input logic [31:0] d, input logic s);
        check_eq({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        check_eq({tag, "_data"}, res_data, d);
        check_eq({tag, "_src"}, {31'b0, res_src}, {31'b0, s});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n   = 1'b0;
        res_ready = 1'b1;
        set_a(1'b1, 32'h0000_00F1, 5'd4, 1'b1);
        set_b(1'b1, 32'h1234_5678, 5'd1, 1'b0);

        // Reset held for two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_a_ready", {31'b0, a_ready}, 32'd0);
            check_eq("rst_b_ready", {31'b0, b_ready}, 32'd0);
            check_eq("rst_res_valid", {31'b0, res_valid}, 32'd0);
            check_eq("rst_res_data", res_data, 32'd0);
        end
        reset_n = 1'b1;
        settle();
        check_eq("first_grant_a", {31'b0, a_ready}, 32'd1);
        check_eq("first_grant_b", {31'b0, b_ready}, 32'd0);
        tick();
        check_res("first_res", 32'h0000_0F10, 1'b0);
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check_eq("drain_valid", {31'b0, res_valid}, 32'd0);
        check_eq("drain_hold", res_data, 32'h0000_0F10);

        // A only: left shift, pass-through, full-range left
        set_a(1'b1, 32'h0000_00F1, 5'd4, 1'b1);
        settle();
        check_eq("left_a_ready", {31'b0, a_ready}, 32'd1);
        tick();
        check_res("left4", 32'h0000_0F10, 1'b0);
        set_a(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0);
        tick();
        check_res("pass0", 32'hDEAD_BEEF, 1'b0);
        set_a(1'b1, 32'h0000_0003, 5'd31, 1'b1);
        tick();
        check_res("left31", 32'h8000_0000, 1'b0);
        set_a(1'b0, 32'h0, 5'd0, 1'b0);

        // B only: arithmetic right shifts
        set_b(1'b1, 32'h8000_0010, 5'd4, 1'b0);
        settle();
        check_eq("right_b_ready", {31'b0, b_ready}, 32'd1);
        check_eq("right_a_ready", {31'b0, a_ready}, 32'd0);
        tick();
        check_res("right4", 32'hF800_0001, 1'b1);
        set_b(1'b1, 32'h8000_0000, 5'd31, 1'b0);
        tick();
        check_res("right31", 32'hFFFF_FFFF, 1'b1);
        set_b(1'b1, 32'h7000_0000, 5'd31, 1'b0);
        tick();
        check_res("right31_pos", 32'h0000_0000, 1'b1);

        // Contention: last grant was B, so A leads and grants alternate
        set_a(1'b1, 32'h0000_0001, 5'd1, 1'b1);
        set_b(1'b1, 32'h8000_0000, 5'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            settle();
            check_eq("cont_a_ready", {31'b0, a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("cont_b_ready", {31'b0, b_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clock);
            #1;
            if (k % 2 == 0) check_res("cont", 32'h0000_0002, 1'b0);
            else            check_res("cont", 32'hC000_0000, 1'b1);
        end
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        check_eq("cont_drain", {31'b0, res_valid}, 32'd0);

        // Backpressure: A result held while B waits
        set_a(1'b1, 32'h0000_0001, 5'd3, 1'b1);
        tick();
        check_res("bp_load", 32'h0000_0008, 1'b0);
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b1, 32'h8000_0010, 5'd4, 1'b0);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check_eq("bp_b_ready", {31'b0, b_ready}, 32'd0);
            check_eq("bp_a_ready", {31'b0, a_ready}, 32'd0);
            @(posedge clock);
            #1;
            check_res("bp_hold", 32'h0000_0008, 1'b0);
        end
        res_ready = 1'b1;
        settle();
        check_eq("bp_release_b_ready", {31'b0, b_ready}, 32'd1);
        @(posedge clock);
        #1;
        check_res("bp_nobubble", 32'hF800_0001, 1'b1);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);

        // Leave last grant on A with a held result, then reset mid-operation
        set_a(1'b1, 32'h0000_0005, 5'd0, 1'b1);
        tick();
        check_res("pre_rst", 32'h0000_0005, 1'b0);
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        res_ready = 1'b0;
        tick();
        check_res("pre_rst_hold", 32'h0000_0005, 1'b0);
        reset_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", {31'b0, res_valid}, 32'd0);
        check_eq("mid_rst_data", res_data, 32'd0);
        reset_n = 1'b1;
        res_ready = 1'b1;
        set_a(1'b1, 32'h0000_0011, 5'd1, 1'b1);
        set_b(1'b1, 32'h0000_0100, 5'd2, 1'b0);
        settle();
        check_eq("post_rst_a_ready", {31'b0, a_ready}, 32'd1);
        check_eq("post_rst_b_ready", {31'b0, b_ready}, 32'd0);
        @(posedge clock);
        #1;
        check_res("post_rst_res", 32'h0000_0022, 1'b0);
        settle();
        check_eq("post_rst_next_b", {31'b0, b_ready}, 32'd1);
        @(posedge clock);
        #1;
        check_res("post_rst_res_b", 32'h0000_0040, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational N-bit barrel shifter between two requesters, A and B.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Results go into a one-entry registered output buffer, tagged with the source requester, and drain under consumer backpressure.
- Sits between the ALU issue logic and writeback wherever two shift sources must share one shifter.

Parameters:
- N, 32, datapath width in bits.
- M, 5, shift-amount width in bits; N = 2**M.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous active-low reset.
- a_valid  input  1  requester A has a request.
- a_ready  output  1  A's request accepted this cycle.
- a_data  input  N  A operand.
- a_shamt  input  M  A shift amount.
- a_left  input  1  A direction: 1 = logical left, 0 = arithmetic right.
- b_valid, b_ready, b_data, b_shamt, b_left  as A, for requester B.
- res_valid  output  1  result buffer holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  N  shifted result.
- res_src  output  1  source of the result: 0 = A, 1 = B.

Behaviour:
- Reset is synchronous and active-low: all flops are cleared on a rising clock edge while reset_n = 0.
  - Reset values: res_valid = 0, res_data = 0, res_src = 0, last_grant = 1 (B), so A wins the first contention.
- Shift semantics:
  - Left: zero fill.
  - Right: arithmetic, replicating bit N-1.
  - shamt = 0 passes the operand through.
  - A full-range shamt of 2**M-1 is legal.
- can_accept = !res_valid || res_ready, so a full buffer draining this cycle may refill in the same cycle.
- Grant is combinational, computed each cycle:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the requester not equal to last_grant.
  - Neither valid -> no grant.
- Ready outputs:
  - a_ready = can_accept && grant == A && a_valid.
  - b_ready = can_accept && grant == B && b_valid.
  - At most one ready is high per cycle. ready never asserts without the matching valid.
- Accept edge (x_valid && x_ready): on that clock edge res_data is loaded with the shifter output for x's operand, shamt and direction, res_src is set to x, res_valid is set to 1, and last_grant is set to x.
- Latency: exactly 1 cycle from the accept edge to res_valid high.
- Drain without refill: if res_valid && res_ready and no accept, res_valid goes to 0 next edge. res_data and res_src hold their values.
- Backpressure: while res_valid && !res_ready, res_data and res_src are stable and both ready outputs are 0.
- last_grant changes only on an accept. A requester that holds valid low does not lose its turn.
- Requesters must hold data, shamt and left stable while valid is high and unaccepted. The block does not check this.
- Reset mid-operation: a buffered result is discarded with no res_valid pulse, and the arbitration pointer returns to the reset value.
- Throughput: one result per cycle when res_ready is held high.
- Fairness: when both requesters stream continuously, grants alternate strictly A, B, A, B.

Decomposition:
- Shared package holds:
  - localparams SRC_A = 1'b0 and SRC_B = 1'b1.
  - Default N/M constants, shared with the ALU.
- One sub-module instance: barrel_shifter (out, in, shiftamt, left) with N and M passed through. Its inputs are muxed from A or B by the grant.
- The arbiter (grant, last_grant flop) and the output buffer (res_valid/res_data/res_src flops) are written inline. No separate FSM module; the state is res_valid × last_grant.

Test Plan:
- Reset:
  - Stimulus: reset_n = 0 for 2 cycles with a_valid = b_valid = 1.
  - Response: a_ready = b_ready = 0 and res_valid = 0 throughout. On release the first grant goes to A.
- Single left shift:
  - Stimulus: A only, data 32'h0000_00F1, shamt 4, left = 1, res_ready = 1.
  - Response: next cycle res_valid = 1, res_data = 32'h0000_0F10, res_src = 0.
- Arithmetic right shift:
  - Stimulus: B only, data 32'h8000_0010, shamt 4, left = 0.
  - Response: res_data = 32'hF800_0001, res_src = 1. Also check shamt 31 on 32'h8000_0000, which must give 32'hFFFF_FFFF.
- Contention:
  - Stimulus: A and B valid continuously for 6 cycles, res_ready = 1.
  - Response: res_src sequence is 0,1,0,1,0,1 and one result per cycle.
- Backpressure:
  - Stimulus: accept A with data 32'h1, shamt 3, left = 1, then hold res_ready = 0 for 3 cycles with B valid.
  - Response: res_data holds 32'h8, and b_ready = 0 for all 3 cycles. In the cycle res_ready rises, b_ready = 1 and B's result appears on the next edge with no bubble.
- Mid-operation reset:
  - Stimulus: pulse reset_n = 0 while res_valid = 1 and res_ready = 0.
  - Response: res_valid = 0 the next cycle, the result is lost, and with both requesters valid A is granted first.
